// File: rtl/ro_meas_controller.sv
// rtl/ro_meas_controller.sv - host command sequencer for ring-oscillator measurement and result streaming
module ro_meas_controller #(
    parameter int N_BYTES    = 3,
    parameter int N_CH       = 4,
    parameter int GAP_CYCLES = 100,
    parameter int USE_BUSY   = 1,
    localparam int SEL_W     = (N_BYTES > 1) ? $clog2(N_BYTES) : 1,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sum_ready,
    input  logic             tx_busy,
    input  logic             rx_ready,
    input  logic [7:0]       rx_data,
    output logic             sum_en,
    output logic             tx_send,
    output logic [SEL_W-1:0] send_sel,
    output logic [CH_W-1:0]  ch_sel,
    output logic             running
);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]    GAP_MAX  = GW'(GAP_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT_SUM,
        S_SEND,
        S_WAIT_SEND
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       pend_data_q, pend_data_d;
    logic             pend_valid_q, pend_valid_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [SEL_W-1:0] byte_idx_q, byte_idx_d;
    logic [CH_W-1:0]  ch_sel_q, ch_sel_d;
    logic             running_q, running_d;
    logic             tx_free;

    assign tx_free = (USE_BUSY == 0) || !tx_busy;

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        pend_data_d  = pend_data_q;
        pend_valid_d = pend_valid_q;
        byte_idx_d   = byte_idx_q;
        ch_sel_d     = ch_sel_q;
        running_d    = running_q;

        // Commands arriving mid-frame are parked; the newest one wins.
        if ((state_q == S_SEND || state_q == S_WAIT_SEND) && rx_ready) begin
            pend_data_d  = rx_data;
            pend_valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_ready) begin
                    cmd_d   = rx_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (cmd_q)
                    8'h00: begin
                        running_d = 1'b1;
                        state_d   = S_WAIT_SUM;
                    end
                    8'h01: begin
                        running_d = 1'b0;
                        state_d   = S_WAIT_SUM;
                    end
                    8'h02: begin
                        running_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                    default: begin
                        if (cmd_q[7:4] == 4'h1 && 32'(cmd_q[3:0]) < N_CH) begin
                            ch_sel_d = cmd_q[CH_W-1:0];
                        end
                        state_d = running_q ? S_WAIT_SUM : S_IDLE;
                    end
                endcase
            end
            S_WAIT_SUM: begin
                if (rx_ready) begin
                    cmd_d   = rx_data;
                    state_d = S_DECODE;
                end else if (sum_ready) begin
                    byte_idx_d = '0;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                state_d = S_WAIT_SEND;
            end
            S_WAIT_SEND: begin
                if (gap_cnt_q >= GAP_MAX && tx_free) begin
                    if (byte_idx_q < LAST_IDX) begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = S_SEND;
                    end else if (pend_valid_d) begin
                        cmd_d        = pend_data_d;
                        pend_valid_d = 1'b0;
                        state_d      = S_DECODE;
                    end else begin
                        state_d = running_q ? S_WAIT_SUM : S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            gap_cnt_d = '0;
        end else if (state_q == S_WAIT_SEND && gap_cnt_q < GAP_MAX) begin
            gap_cnt_d = gap_cnt_q + 1'b1;
        end else begin
            gap_cnt_d = gap_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            pend_data_q  <= '0;
            pend_valid_q <= 1'b0;
            gap_cnt_q    <= '0;
            byte_idx_q   <= '0;
            ch_sel_q     <= '0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            pend_data_q  <= pend_data_d;
            pend_valid_q <= pend_valid_d;
            gap_cnt_q    <= gap_cnt_d;
            byte_idx_q   <= byte_idx_d;
            ch_sel_q     <= ch_sel_d;
            running_q    <= running_d;
        end
    end

    assign sum_en   = (state_q == S_WAIT_SUM);
    assign tx_send  = (state_q == S_SEND);
    assign send_sel = (state_q == S_SEND || state_q == S_WAIT_SEND) ? byte_idx_q : '0;
    assign ch_sel   = ch_sel_q;
    assign running  = running_q;

endmodule

// File: tb/tb_ro_meas_controller.sv
// tb/tb_ro_meas_controller.sv - scoreboard bench for ro_meas_controller with a transaction-level model
module tb_ro_meas_controller;
    localparam int NB  = 3;
    localparam int NCH = 4;
    localparam int G   = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reset0 = 1'b1;
    logic       sum_ready = 1'b0;
    logic       tx_busy = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic       sum_en1, tx_send1, running1, sum_en0, tx_send0, running0;
    logic [1:0] send_sel1, ch_sel1, send_sel0, ch_sel0;

    ro_meas_controller #(.N_BYTES(NB), .N_CH(NCH), .GAP_CYCLES(G), .USE_BUSY(1)) dut1 (
        .clk(clk), .reset(reset), .sum_ready(sum_ready), .tx_busy(tx_busy),
        .rx_ready(rx_ready), .rx_data(rx_data), .sum_en(sum_en1), .tx_send(tx_send1),
        .send_sel(send_sel1), .ch_sel(ch_sel1), .running(running1)
    );

    ro_meas_controller #(.N_BYTES(NB), .N_CH(NCH), .GAP_CYCLES(G), .USE_BUSY(0)) dut0 (
        .clk(clk), .reset(reset0), .sum_ready(sum_ready), .tx_busy(tx_busy),
        .rx_ready(rx_ready), .rx_data(rx_data), .sum_en(sum_en0), .tx_send(tx_send0),
        .send_sel(send_sel0), .ch_sel(ch_sel0), .running(running0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int sel;
        int ch;
        int cyc;
    } exp_t;

    exp_t exp1[$];
    exp_t exp0[$];
    int   checks = 0;
    int   errors = 0;

    // Transaction-level model: current channel, run flag, latest parked command.
    int m_ch = 0;
    int m_run = 0;
    int m_pend = -1;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic m_apply(input int b);
        if (b == 0) m_run = 1;
        else if (b == 1 || b == 2) m_run = 0;
        else if ((b >> 4) == 1 && (b & 15) < NCH) m_ch = b & 15;
    endtask

    task automatic push_frame(input int s);
        for (int i = 0; i < NB; i++) exp1.push_back('{i, m_ch, s + i * (G + 1)});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic rx(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sum_en"}, int'(sum_en1), 0);
        check({tag, "_tx_send"}, int'(tx_send1), 0);
        check({tag, "_send_sel"}, int'(send_sel1), 0);
        check({tag, "_ch_sel"}, int'(ch_sel1), 0);
        check({tag, "_running"}, int'(running1), 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_send1) begin
                if (exp1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_send1: sel=%0d at cycle %0d, expected no send", send_sel1, cyc);
                end else begin
                    e = exp1.pop_front();
                    check("send1_sel", int'(send_sel1), e.sel);
                    check("send1_ch", int'(ch_sel1), e.ch);
                    check("send1_cycle", cyc, e.cyc);
                end
            end
            if (tx_send0) begin
                if (exp0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_send0: sel=%0d at cycle %0d, expected no send", send_sel0, cyc);
                end else begin
                    e = exp0.pop_front();
                    check("send0_sel", int'(send_sel0), e.sel);
                    check("send0_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int t, s, s2, d, k, b, len, b1;
        tick(3);
        reset = 1'b0;
        check_idle_outputs("reset");

        k = $urandom_range(0, 15);
        rx(8'(8'h10 | k));
        m_apply(8'h10 | k);
        tick(2);
        check("idle_select_ch", int'(ch_sel1), m_ch);
        check("idle_select_sum_en", int'(sum_en1), 0);

        // Continuous run, two frames, STOP parked in the second frame.
        sum_ready = 1'b1;
        t = cyc;
        rx(8'h00);
        m_apply(0);
        check("start_decode_sum_en", int'(sum_en1), 0);
        tick(1);
        check("start_sum_en", int'(sum_en1), 1);
        check("start_running", int'(running1), 1);
        s = t + 3;
        push_frame(s);
        s2 = s + NB * (G + 1) + 1;
        push_frame(s2);
        wait_until(s2 + $urandom_range(0, 290));
        rx(8'h02);
        m_pend = 2;
        wait_until(s2 + NB * (G + 1) + 3);
        m_apply(m_pend);
        m_pend = -1;
        check("stop_sum_en", int'(sum_en1), 0);
        check("stop_running", int'(running1), m_run);

        // SINGLE with a randomly delayed sum_ready.
        sum_ready = 1'b0;
        t = cyc;
        rx(8'h01);
        m_apply(1);
        d = $urandom_range(2, 20);
        wait_until(t + d);
        sum_ready = 1'b1;
        push_frame(t + d + 1);
        wait_until(t + d + 1 + NB * (G + 1) + 5);
        check("single_sum_en", int'(sum_en1), 0);
        check("single_running", int'(running1), 0);
        sum_ready = 1'b0;

        // Channel changes while running; one with a colliding sum_ready.
        rx(8'h00);
        m_apply(0);
        tick(2);
        for (int i = 0; i < 6; i++) begin
            if (i == 0) b = 8'h12;
            else if (i == 1) b = 8'h17;
            else if ($urandom_range(0, 3) == 0) b = 8'h40 + $urandom_range(0, 31);
            else b = 8'h10 | $urandom_range(0, 15);
            check("sel_pre_sum_en", int'(sum_en1), 1);
            sum_ready = (i == 2);
            rx(8'(b));
            sum_ready = 1'b0;
            m_apply(b);
            check("sel_decode_sum_en", int'(sum_en1), 0);
            tick(1);
            check("sel_post_sum_en", int'(sum_en1), 1);
            check("sel_ch", int'(ch_sel1), m_ch);
            check("sel_running", int'(running1), 1);
        end

        // STOP then SELECT parked during the frame: only the latest executes.
        t = cyc;
        sum_ready = 1'b1;
        tick(1);
        sum_ready = 1'b0;
        push_frame(t + 1);
        wait_until(t + 103 + $urandom_range(0, 40));
        rx(8'h02);
        m_pend = 2;
        wait_until(t + 150 + $urandom_range(0, 40));
        rx(8'h13);
        m_pend = 8'h13;
        wait_until(t + 306);
        m_apply(m_pend);
        m_pend = -1;
        check("pend_sum_en", int'(sum_en1), 1);
        check("pend_running", int'(running1), m_run);
        check("pend_ch", int'(ch_sel1), m_ch);

        // Busy pacing: USE_BUSY=1 waits for tx_busy, USE_BUSY=0 ignores it.
        reset = 1'b1;
        reset0 = 1'b1;
        tick(2);
        reset = 1'b0;
        reset0 = 1'b0;
        m_ch = 0;
        m_run = 0;
        sum_ready = 1'b1;
        t = cyc;
        rx(8'h01);
        m_apply(1);
        s = t + 3;
        len = $urandom_range(100, 300);
        b1 = (s + G + 1 > s + len + 1) ? s + G + 1 : s + len + 1;
        exp1.push_back('{0, m_ch, s});
        exp1.push_back('{1, m_ch, b1});
        exp1.push_back('{2, m_ch, b1 + G + 1});
        for (int i = 0; i < NB; i++) exp0.push_back('{i, 0, s + i * (G + 1)});
        wait_until(s);
        tx_busy = 1'b1;
        wait_until(s + len);
        tx_busy = 1'b0;
        wait_until(b1 + 2 * (G + 1) + 10);
        sum_ready = 1'b0;
        reset0 = 1'b1;

        // Reset in the middle of byte 1 with a parked command.
        rx(8'h11);
        m_apply(8'h11);
        tick(1);
        sum_ready = 1'b1;
        t = cyc;
        rx(8'h00);
        m_apply(0);
        s = t + 3;
        exp1.push_back('{0, m_ch, s});
        exp1.push_back('{1, m_ch, s + G + 1});
        wait_until(s + G + 3 + $urandom_range(0, 30));
        rx(8'h13);
        wait_until(s + G + 50 + $urandom_range(0, 40));
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        m_ch = 0;
        m_run = 0;
        check_idle_outputs("midreset");
        tick(400);
        check("post_reset_sum_en", int'(sum_en1), 0);
        check("post_reset_running", int'(running1), 0);
        sum_ready = 1'b0;

        tick(2);
        check("scoreboard1_drained", exp1.size(), 0);
        check("scoreboard0_drained", exp0.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
